// File: rtl/soc_timer_bank.sv
// Multi-channel prescaled down-counter bank with a free-running cycle counter,
// attached to the picorv32 native memory bus as a single decode slot.
module soc_timer_bank #(
   parameter int NUM_CH     = 4,
   parameter int WIDTH      = 32,
   parameter int PRESCALE_W = 16
) (
   input  logic              clk_24,
   input  logic              reset,
   input  logic              sel,
   input  logic [3:0]        wstrb,
   input  logic [5:0]        addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              rdy,
   output logic [NUM_CH-1:0] irq,
   output logic              irq_any
);

   localparam logic [5:0] ADDR_CYCLE = 6'h20;
   localparam logic [5:0] ADDR_PEND  = 6'h21;

   // Byte-strobed merge of a WIDTH-bit register; bits above WIDTH are dropped.
   function automatic logic [WIDTH-1:0] merge_w(input logic [WIDTH-1:0] cur,
                                                input logic [31:0] d,
                                                input logic [3:0] s);
      logic [WIDTH-1:0] v;
      for (int i = 0; i < WIDTH; i++) v[i] = s[i/8] ? d[i] : cur[i];
      return v;
   endfunction

   function automatic logic [PRESCALE_W-1:0] merge_pre(input logic [PRESCALE_W-1:0] cur,
                                                      input logic [31:0] d,
                                                      input logic [3:0] s);
      logic [PRESCALE_W-1:0] v;
      for (int i = 0; i < PRESCALE_W; i++) v[i] = s[(16+i)/8] ? d[16+i] : cur[i];
      return v;
   endfunction

   logic             r_rdy;
   logic [31:0]      r_rdata;
   logic [WIDTH-1:0] r_cycle;

   logic             w_accept;
   logic             w_wr;
   logic [31:0]      w_rd;
   logic [31:0]      w_ctrl_rd   [NUM_CH];
   logic [31:0]      w_count_rd  [NUM_CH];
   logic [31:0]      w_reload_rd [NUM_CH];
   logic [31:0]      w_status_rd [NUM_CH];
   logic [NUM_CH-1:0] w_irq;

   // A held sel during the rdy cycle is the tail of the same access.
   assign w_accept = sel & ~r_rdy;
   assign w_wr     = w_accept & (|wstrb);

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic                  r_en;
         logic                  r_per;
         logic                  r_ie;
         logic                  r_exp;
         logic [PRESCALE_W-1:0] r_pre;
         logic [PRESCALE_W-1:0] r_pc;
         logic [WIDTH-1:0]      r_count;
         logic [WIDTH-1:0]      r_reload;

         logic w_hit;
         logic w_wr_ctrl;
         logic w_wr_count;
         logic w_wr_reload;
         logic w_wr_status;
         logic w_en_new;
         logic w_start;
         logic w_tick;
         logic w_expire;

         assign w_hit       = w_wr & (addr[5:2] == 4'(gi));
         assign w_wr_ctrl   = w_hit & (addr[1:0] == 2'd0);
         assign w_wr_count  = w_hit & (addr[1:0] == 2'd1);
         assign w_wr_reload = w_hit & (addr[1:0] == 2'd2);
         assign w_wr_status = w_hit & (addr[1:0] == 2'd3);

         assign w_en_new = wstrb[0] ? wdata[0] : r_en;
         assign w_start  = w_wr_ctrl & w_en_new & ~r_en;
         assign w_tick   = r_en & (r_pc == r_pre);
         // A CPU COUNT write swallows a coincident tick, including its expiry.
         assign w_expire = w_tick & (r_count == '0) & ~w_wr_count;

         always_ff @(posedge clk_24) begin
            if (reset) begin
               r_en     <= 1'b0;
               r_per    <= 1'b0;
               r_ie     <= 1'b0;
               r_exp    <= 1'b0;
               r_pre    <= '0;
               r_pc     <= '0;
               r_count  <= '0;
               r_reload <= '0;
            end else begin
               if (w_start | w_wr_count)
                  r_pc <= '0;
               else if (r_en)
                  r_pc <= w_tick ? '0 : r_pc + PRESCALE_W'(1);

               if (w_wr_count)
                  r_count <= merge_w(r_count, wdata, wstrb);
               else if (w_tick) begin
                  if (r_count != '0)
                     r_count <= r_count - WIDTH'(1);
                  else if (r_per)
                     r_count <= r_reload;
               end

               if (w_wr_reload)
                  r_reload <= merge_w(r_reload, wdata, wstrb);

               if (w_wr_ctrl) begin
                  r_en  <= w_en_new;
                  r_per <= wstrb[0] ? wdata[1] : r_per;
                  r_ie  <= wstrb[0] ? wdata[2] : r_ie;
                  r_pre <= merge_pre(r_pre, wdata, wstrb);
               end else if (w_expire & ~r_per) begin
                  r_en <= 1'b0;
               end

               // Set beats a simultaneous write-1-to-clear.
               r_exp <= w_expire | (r_exp & ~(w_wr_status & wstrb[0] & wdata[0]));
            end
         end

         assign w_ctrl_rd[gi]   = 32'({r_pre, 13'b0, r_ie, r_per, r_en});
         assign w_count_rd[gi]  = 32'(r_count);
         assign w_reload_rd[gi] = 32'(r_reload);
         assign w_status_rd[gi] = 32'(r_exp);
         assign w_irq[gi]       = r_exp & r_ie;
      end
   endgenerate

   always_comb begin
      w_rd = '0;
      if (addr == ADDR_CYCLE)
         w_rd = 32'(r_cycle);
      else if (addr == ADDR_PEND)
         w_rd = 32'(w_irq);
      else if (!addr[5]) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (addr[4:2] == 3'(c)) begin
               case (addr[1:0])
                  2'd0:    w_rd = w_ctrl_rd[c];
                  2'd1:    w_rd = w_count_rd[c];
                  2'd2:    w_rd = w_reload_rd[c];
                  default: w_rd = w_status_rd[c];
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk_24) begin
      if (reset) begin
         r_rdy   <= 1'b0;
         r_rdata <= '0;
         r_cycle <= '0;
      end else begin
         r_rdy <= w_accept;
         if (w_accept)
            r_rdata <= w_rd;
         if (w_wr && (addr == ADDR_CYCLE))
            r_cycle <= merge_w(r_cycle, wdata, wstrb);
         else
            r_cycle <= r_cycle + WIDTH'(1);
      end
   end

   assign rdata   = r_rdata;
   assign rdy     = r_rdy;
   assign irq     = w_irq;
   assign irq_any = |w_irq;

endmodule

// File: tb/tb_soc_timer_bank.sv
// Randomised and directed bench for soc_timer_bank; expected channel state is
// computed in closed form from elapsed cycles since the enabling write.
module tb_soc_timer_bank;

   localparam int NCH = 4;

   logic        clk_24 = 1'b0;
   logic        reset  = 1'b1;
   logic        sel    = 1'b0;
   logic [3:0]  wstrb  = 4'h0;
   logic [5:0]  addr   = 6'h0;
   logic [31:0] wdata  = 32'h0;
   wire  [31:0] rdata;
   wire         rdy;
   wire  [NCH-1:0] irq;
   wire         irq_any;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // CYCLE model: value after edge e is cyc_base + (e - cyc_edge).
   logic [31:0] cyc_base = 32'h0;
   int          cyc_edge = 0;

   soc_timer_bank #(.NUM_CH(NCH), .WIDTH(32), .PRESCALE_W(16)) dut (
      .clk_24  (clk_24),
      .reset   (reset),
      .sel     (sel),
      .wstrb   (wstrb),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .rdy     (rdy),
      .irq     (irq),
      .irq_any (irq_any)
   );

   always #5 clk_24 = ~clk_24;
   always @(posedge clk_24) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h (edge %0d)", tag, got, want, cyc);
      end
   endtask

   // One bus access; returns read data and the edge number that accepted it.
   task automatic bus(input logic [5:0] a, input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] q, output int ea);
      @(negedge clk_24);
      sel = 1'b1; addr = a; wstrb = s; wdata = d;
      @(negedge clk_24);
      sel = 1'b0; wstrb = 4'h0;
      ea = cyc;
      q  = rdata;
      $display("xact addr=%h strb=%h wdata=%h rdata=%h edge=%0d", a, s, d, q, ea);
      chk("rdy_pulse", {31'b0, rdy}, 32'd1);
   endtask

   task automatic rd(input logic [5:0] a, output logic [31:0] q, output int ea);
      bus(a, 4'h0, 32'h0, q, ea);
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d, output int ea);
      logic [31:0] q;
      bus(a, 4'hF, d, q, ea);
   endtask

   // Leave the bench at a negedge such that the next bus() is accepted at edge x.
   task automatic wait_until(input int x);
      chk("sched_in_time", {31'b0, cyc <= x - 2}, 32'd1);
      for (int i = 0; i < 1000 && cyc < x - 2; i++) @(negedge clk_24);
   endtask

   function automatic logic [5:0] caddr(input int c, input int ri);
      return 6'(c * 4 + ri);
   endfunction

   function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
      logic [31:0] v;
      v = old;
      for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
      return v;
   endfunction

   function automatic logic [31:0] cyc_at(input int e);
      return cyc_base + 32'(e - cyc_edge);
   endfunction

   // State k edges after the enabling write: ticks happen every (p+1) edges,
   // N ticks count down, tick N+1 expires, then reload period is r+1 ticks.
   function automatic void predict(input int k, input int n, input int p, input int r,
                                   input bit per, output int cnt, output bit ex,
                                   output bit en);
      int t;
      int u;
      t = k / (p + 1);
      if (t <= n) begin
         cnt = n - t; ex = 1'b0; en = 1'b1;
      end else if (!per) begin
         cnt = 0; ex = 1'b1; en = 1'b0;
      end else begin
         u = t - (n + 1);
         cnt = r - (u % (r + 1)); ex = 1'b1; en = 1'b1;
      end
   endfunction

   function automatic logic [31:0] ctrl_val(input int p, input bit ie, input bit per,
                                            input bit en);
      return (32'(p) << 16) | (32'(ie) << 2) | (32'(per) << 1) | 32'(en);
   endfunction

   task automatic prog(input int c, input int n, input int p, input int r,
                       input bit per, input bit ie, output int e0);
      int ea;
      wr(caddr(c, 0), 32'h0, ea);
      wr(caddr(c, 3), 32'h1, ea);
      wr(caddr(c, 2), 32'(r), ea);
      wr(caddr(c, 1), 32'(n), ea);
      wr(caddr(c, 0), ctrl_val(p, ie, per, 1'b1), e0);
   endtask

   task automatic quiesce(input int c);
      int ea;
      wr(caddr(c, 0), 32'h0, ea);
      wr(caddr(c, 3), 32'h1, ea);
   endtask

   initial begin
      logic [31:0] q, q1;
      int ea, e0, e1, cnt;
      bit ex, en;

      // Reset state
      repeat (3) @(negedge clk_24);
      chk("rst_rdy", {31'b0, rdy}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      reset = 1'b0;
      cyc_base = 32'h0;
      cyc_edge = cyc;

      // CYCLE free-runs: two reads two edges apart differ by 2
      rd(6'h20, q1, e1);
      chk("cycle_first", q1, cyc_at(e1 - 1));
      rd(6'h20, q, ea);
      chk("cycle_step2", q - q1, 32'd2);
      @(negedge clk_24);
      chk("rdy_single", {31'b0, rdy}, 32'd0);
      chk("irq_idle", 32'(irq), 32'd0);

      // Ch0 one-shot: N=3, P=0 -> expiry 4 edges after enable
      prog(0, 3, 0, 0, 1'b0, 1'b1, e0);
      for (int i = 0; i < 100 && cyc < e0 + 3; i++) @(negedge clk_24);
      chk("ch0_irq_before", {31'b0, irq[0]}, 32'd0);
      @(negedge clk_24);
      chk("ch0_irq_at4", {31'b0, irq[0]}, 32'd1);
      chk("ch0_irq_any", {31'b0, irq_any}, 32'd1);
      rd(caddr(0, 0), q, ea);
      chk("ch0_ctrl_en_clr", q, 32'h4);
      rd(caddr(0, 1), q, ea);
      chk("ch0_count0", q, 32'h0);
      quiesce(0);

      // Ch1 periodic N=1 R=1 P=2: expiries at +6, +12, ...
      prog(1, 1, 2, 1, 1'b1, 1'b0, e0);
      wait_until(e0 + 7);
      rd(caddr(1, 3), q, ea);
      chk("ch1_exp_first", q, 32'h1);
      wr(caddr(1, 3), 32'h1, ea);
      rd(caddr(1, 3), q, ea);
      chk("ch1_exp_cleared", q, 32'h0);
      wait_until(e0 + 13);
      rd(caddr(1, 3), q, ea);
      chk("ch1_exp_reset", q, 32'h1);
      chk("ch1_no_irq", {31'b0, irq[1]}, 32'd0);
      quiesce(1);

      // Ch2: W1C on the expiry edge, set wins
      prog(2, 2, 1, 0, 1'b0, 1'b1, e0);
      wait_until(e0 + 6);
      wr(caddr(2, 3), 32'h1, ea);
      rd(caddr(2, 3), q, ea);
      chk("ch2_set_wins", q, 32'h1);
      quiesce(2);

      // Ch2: COUNT write on a tick edge, then off a tick edge
      prog(2, 5, 2, 0, 1'b1, 1'b0, e0);
      wait_until(e0 + 6);
      wr(caddr(2, 1), 32'd4, ea);
      rd(caddr(2, 1), q, ea);
      chk("ch2_wr_beats_tick", q, 32'd4);
      rd(caddr(2, 1), q, ea);
      chk("ch2_next_tick", q, 32'd3);
      wait_until(e0 + 13);
      wr(caddr(2, 1), 32'd2, ea);
      wait_until(e0 + 16);
      rd(caddr(2, 1), q, ea);
      chk("ch2_pc_restart", q, 32'd2);
      rd(caddr(2, 1), q, ea);
      chk("ch2_after_restart", q, 32'd1);
      quiesce(2);

      // Ch3: EN=0 write coincident with one-shot expiry
      prog(3, 1, 0, 0, 1'b0, 1'b1, e0);
      wait_until(e0 + 2);
      wr(caddr(3, 0), 32'h4, ea);
      rd(caddr(3, 3), q, ea);
      chk("ch3_exp_on_dis", q, 32'h1);
      rd(caddr(3, 0), q, ea);
      chk("ch3_ctrl", q, 32'h4);
      chk("ch3_irq", {31'b0, irq[3]}, 32'd1);
      quiesce(3);

      // CYCLE byte write
      wr(6'h20, 32'h12345677, e1);
      cyc_base = 32'h12345677;
      cyc_edge = e1;
      bus(6'h20, 4'b0010, 32'h0000AB00, q, e1);
      cyc_base = bmerge(cyc_at(e1 - 1), 32'h0000AB00, 4'b0010);
      cyc_edge = e1;
      rd(6'h20, q, ea);
      chk("cycle_bytewr", q, 32'h1234AB79);
      chk("cycle_model", q, cyc_at(ea - 1));

      // Unmapped channel / offset
      wr(6'h1C, 32'hFFFFFFFF, ea);
      wr(6'h1D, 32'hFFFFFFFF, ea);
      rd(6'h1C, q, ea);
      chk("unmapped_70", q, 32'h0);
      rd(6'h1D, q, ea);
      chk("unmapped_74", q, 32'h0);
      rd(6'h22, q, ea);
      chk("unmapped_88", q, 32'h0);
      chk("unmapped_irq", 32'(irq), 32'd0);

      // Randomised single-channel runs against the closed-form model
      for (int it = 0; it < 24; it++) begin
         int c, n, p, r, k;
         bit per, ie;
         c   = $urandom_range(0, NCH - 1);
         n   = $urandom_range(0, 4);
         p   = $urandom_range(0, 3);
         r   = $urandom_range(0, 3);
         per = 1'($urandom_range(0, 1));
         ie  = 1'($urandom_range(0, 1));
         prog(c, n, p, r, per, ie, e0);
         repeat ($urandom_range(0, 30)) @(negedge clk_24);
         rd(caddr(c, 1), q, ea);
         predict(ea - 1 - e0, n, p, r, per, cnt, ex, en);
         chk("rnd_count", q, 32'(cnt));
         rd(caddr(c, 3), q, ea);
         predict(ea - 1 - e0, n, p, r, per, cnt, ex, en);
         chk("rnd_status", q, 32'(ex));
         rd(caddr(c, 0), q, ea);
         predict(ea - 1 - e0, n, p, r, per, cnt, ex, en);
         chk("rnd_ctrl", q, ctrl_val(p, ie, per, en));
         rd(6'h21, q, ea);
         predict(ea - 1 - e0, n, p, r, per, cnt, ex, en);
         chk("rnd_pend", q, 32'(ex & ie) << c);
         k = cyc - e0;
         predict(k, n, p, r, per, cnt, ex, en);
         chk("rnd_irq", {31'b0, irq[c]}, 32'(ex & ie));
         chk("rnd_irq_any", {31'b0, irq_any}, 32'(ex & ie));
         quiesce(c);
      end

      // Reset during an active periodic count with EXP set, mid-access
      prog(1, 0, 0, 0, 1'b1, 1'b1, e0);
      @(negedge clk_24);
      chk("pre_rst_irq_any", {31'b0, irq_any}, 32'd1);
      sel = 1'b1; addr = 6'h20; wstrb = 4'h0; reset = 1'b1;
      @(negedge clk_24);
      sel = 1'b0;
      chk("rst_abort_rdy", {31'b0, rdy}, 32'd0);
      @(negedge clk_24);
      reset = 1'b0;
      cyc_base = 32'h0;
      cyc_edge = cyc;
      @(negedge clk_24);
      chk("post_rst_rdy", {31'b0, rdy}, 32'd0);
      chk("post_rst_irq", 32'(irq), 32'd0);
      chk("post_rst_irq_any", {31'b0, irq_any}, 32'd0);
      for (int ri = 0; ri < 4; ri++) begin
         rd(caddr(1, ri), q, ea);
         chk("post_rst_reg", q, 32'h0);
      end
      rd(6'h20, q, ea);
      chk("post_rst_cycle", q, cyc_at(ea - 1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/soc_timer_bank.md
Name: soc_timer_bank

Overview:
- Parametrised multi-channel timer peripheral for the picorv32 native memory bus. It is the successor to the single free-running, writable clock counter in the SoC.
- Provides NUM_CH independent down-counters, each with prescaler, one-shot/periodic mode and interrupt. Also keeps the legacy free-running cycle counter as a global register.
- Occupies one SoC decode slot. The top level drives sel from its address decode and ORs rdy into mem_ready.

Parameters:
- NUM_CH, 4, number of timer channels (1..8).
- WIDTH, 32, bit width of COUNT, RELOAD and CYCLE (8..32).
- PRESCALE_W, 16, prescaler field width (1..16).

Ports:
- clk_24  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sel  input  1  slot select (address decode & mem_valid)
- wstrb  input  4  byte write strobes; 0 = read
- addr  input  6  word address, mem_addr[7:2]
- wdata  input  32  write data
- rdata  output  32  registered read data
- rdy  output  1  access-complete pulse
- irq  output  NUM_CH  per-channel interrupt, level
- irq_any  output  1  OR of irq

Behaviour:
- Register map by byte offset:
  - Channel c at 0x10*c: +0x0 CTRL, +0x4 COUNT, +0x8 RELOAD, +0xC STATUS.
  - 0x80 CYCLE; 0x84 IRQ_PEND (read-only, bit c = irq[c]).
  - Channels >= NUM_CH and unmapped offsets read 0; writes to them are ignored.
- CTRL fields: [0] EN, [1] PERIODIC, [2] IE, [16+PRESCALE_W-1:16] PRE. All other bits read 0.
- STATUS fields: [0] EXP, sticky, write-1-to-clear.
- Handshake:
  - An access is accepted in any cycle with sel=1 and rdy=0.
  - Write data commits at that edge, honouring wstrb per byte.
  - rdata is registered at the same edge; rdy=1 for exactly the next cycle, then 0.
  - sel held high while rdy=1 is not a new access. Back-to-back accesses therefore take 2 cycles each.
  - Reads have no side effects.
- Width rules:
  - Registers narrower than 32 bits are zero-extended on read.
  - Write bits above WIDTH (or above the PRE field) are ignored.
- Channel operation (per channel, every cycle EN=1):
  - Prescaler pc: if pc==PRE, tick and pc<=0; else pc<=pc+1.
  - On tick with COUNT!=0: COUNT<=COUNT-1.
  - On tick with COUNT==0: EXP<=1. Then, if PERIODIC, COUNT<=RELOAD; else EN<=0 and COUNT stays 0.
  - Timing: with COUNT=N and PRE=P loaded, EXP is first set (N+1)*(P+1) cycles after the edge committing EN 0->1. It is visible from the following cycle.
  - While EN=0, COUNT and pc hold.
- pc<=0 on any commit that sets EN 0->1 and on any COUNT write.
- Simultaneous events:
  - CPU COUNT write and tick in the same cycle: the CPU write wins and the tick is discarded.
  - EXP W1C and expiry in the same cycle: EXP stays 1 (set wins).
  - CPU write of EN=0 and a one-shot expiry in the same cycle: EN=0 and EXP=1.
- PERIODIC with RELOAD=0: expires every tick.
- COUNT wraps never. Decrement stops at 0; reload or disable happens at 0.
- irq[c] = EXP[c] & IE[c], combinational from registered state. irq_any = |irq.
- CYCLE: increments by 1 every cycle, modulo 2^WIDTH. A write with any wstrb bit set loads the strobed bytes instead of incrementing that cycle.
- Reset:
  - All CTRL, COUNT, RELOAD, STATUS, pc and CYCLE go to 0; rdy=0, rdata=0, irq=0.
  - Reset asserted mid-access or mid-count aborts it. No rdy pulse is produced for the aborted access.

Test Plan:
- Reset, then read 0x80 twice, 2 cycles apart -> second value = first + 2. rdy pulses 1 cycle after each accept. All irq=0.
- Ch0: RELOAD=0, COUNT=3, CTRL=0x5 (EN, IE, PRE=0, one-shot) -> EXP and irq[0] rise exactly 4 cycles after the CTRL commit edge. CTRL reads 0x4 (EN cleared). COUNT reads 0.
- Ch1: COUNT=1, RELOAD=1, CTRL=0x00020003 (PERIODIC, PRE=2) -> EXP after 6 cycles. Write STATUS=1 clears it; it re-sets every 6 cycles thereafter. irq[1] stays 0 (IE=0).
- Ch2 expiring in the same cycle as a STATUS=1 W1C -> EXP reads 1. COUNT write coincident with a tick -> COUNT reads the written value and the next tick is P+1 cycles later.
- Write CYCLE with wstrb=4'b0010, wdata=0x0000AB00 from CYCLE=0x12345678 -> next-cycle value 0x1234AB79. Accesses to 0x70 (NUM_CH=4) read 0 and do not write.
- Assert reset during an active periodic count with EXP=1 -> all registers read 0, irq=0, irq_any=0 after release.
